// File: rtl/load_ctrl_mc_if.sv
// Port bundle for load_ctrl_mc: upstream fill handshake, firmware read requests and status outputs.
interface load_ctrl_mc_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 32,
    parameter int NUM_CH     = 2,
    parameter int CH_BITS    = 4,
    parameter int FILL_W     = 4
);
    logic [NUM_CH*DATA_WIDTH-1:0] data_in;
    logic [NUM_CH-1:0]            data_in_rdy;
    logic [NUM_CH-1:0]            data_in_vld;
    logic                         request_vld;
    logic [CH_BITS-1:0]           request_ch;
    logic [ADDR_WIDTH-1:0]        request_addr;
    logic [DATA_WIDTH-1:0]        data_out;
    logic                         data_out_vld;
    logic [CH_BITS-1:0]           data_out_ch;
    logic [NUM_CH*FILL_W-1:0]     fill_level;
    logic                         event_read_req_when_no_data_is_available;
    logic                         event_addr_out_of_order;
    logic                         event_bad_channel;

    modport master (
        output data_in, data_in_rdy, request_vld, request_ch, request_addr,
        input  data_in_vld, data_out, data_out_vld, data_out_ch, fill_level,
        input  event_read_req_when_no_data_is_available, event_addr_out_of_order, event_bad_channel
    );

    modport slave (
        input  data_in, data_in_rdy, request_vld, request_ch, request_addr,
        output data_in_vld, data_out, data_out_vld, data_out_ch, fill_level,
        output event_read_req_when_no_data_is_available, event_addr_out_of_order, event_bad_channel
    );
endinterface

// File: rtl/load_ctrl_mc.sv
// Multi-channel load controller: per-channel FIFOs filled from upstream, drained by addressed reads.
// Optional macro LOAD_CTRL_MC_ADDR_CHECK_EN enables per-channel address sequence tracking.
module load_ctrl_mc #(
    parameter int                    DATA_WIDTH  = 16,
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    FIFO_DEPTH  = 8,
    parameter int                    NUM_CH      = 2,
    parameter int                    CH_BITS     = 4,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = {ADDR_WIDTH{1'b0}},
    parameter int                    ADDR_STRIDE = 4
) (
    input  logic          clk,
    input  logic          rstn,
    load_ctrl_mc_if.slave bus
);
    localparam int                PTR_W    = $clog2(FIFO_DEPTH);
    localparam int                FILL_W   = PTR_W + 1;
    localparam logic [FILL_W-1:0] DEPTH_C  = FILL_W'(FIFO_DEPTH);
    localparam logic [FILL_W-1:0] FILL_ONE = FILL_W'(1);
    localparam logic [PTR_W-1:0]  PTR_ONE  = PTR_W'(1);
    localparam logic [CH_BITS:0]  NUM_CH_C = (CH_BITS + 1)'(NUM_CH);

    logic [DATA_WIDTH-1:0] mem_q    [NUM_CH][FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q [NUM_CH];
    logic [PTR_W-1:0]      rd_ptr_q [NUM_CH];
    logic [FILL_W-1:0]     cnt_q    [NUM_CH];

    logic [NUM_CH-1:0]     push_s;
    logic [NUM_CH-1:0]     pop_s;
    logic                  ch_ok_s;
    logic                  bad_ch_s;
    logic                  empty_rd_s;
    logic                  oo_s;
    logic [DATA_WIDTH-1:0] pop_data_s;

    logic [DATA_WIDTH-1:0] data_out_q;
    logic                  data_out_vld_q;
    logic [CH_BITS-1:0]    data_out_ch_q;
    logic                  empty_ev_q;
    logic                  oo_ev_q;
    logic                  bad_ev_q;

    // Decode the request into per-channel pops and event conditions; pushes never see a same-cycle pop.
    always_comb begin
        ch_ok_s    = bus.request_vld && ({1'b0, bus.request_ch} < NUM_CH_C);
        bad_ch_s   = bus.request_vld && !({1'b0, bus.request_ch} < NUM_CH_C);
        push_s     = {NUM_CH{1'b0}};
        pop_s      = {NUM_CH{1'b0}};
        empty_rd_s = 1'b0;
        pop_data_s = {DATA_WIDTH{1'b0}};
        for (int c = 0; c < NUM_CH; c++) begin
            push_s[c]  = bus.data_in_rdy[c] && (cnt_q[c] != DEPTH_C);
            pop_s[c]   = ch_ok_s && (bus.request_ch == CH_BITS'(c)) && (cnt_q[c] != {FILL_W{1'b0}});
            empty_rd_s = empty_rd_s
                       | (ch_ok_s && (bus.request_ch == CH_BITS'(c)) && (cnt_q[c] == {FILL_W{1'b0}}));
            pop_data_s = pop_s[c] ? mem_q[c][rd_ptr_q[c]] : pop_data_s;
        end
    end

    assign bus.data_in_vld = push_s;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_fill
        assign bus.fill_level[g*FILL_W +: FILL_W] = cnt_q[g];
    end

    // Per-channel storage, circular pointers and occupancy counters.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int c = 0; c < NUM_CH; c++) begin
                wr_ptr_q[c] <= {PTR_W{1'b0}};
                rd_ptr_q[c] <= {PTR_W{1'b0}};
                cnt_q[c]    <= {FILL_W{1'b0}};
                for (int e = 0; e < FIFO_DEPTH; e++) begin
                    mem_q[c][e] <= {DATA_WIDTH{1'b0}};
                end
            end
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (push_s[c]) begin
                    mem_q[c][wr_ptr_q[c]] <= bus.data_in[c*DATA_WIDTH +: DATA_WIDTH];
                    wr_ptr_q[c]           <= wr_ptr_q[c] + PTR_ONE;
                end
                if (pop_s[c]) begin
                    rd_ptr_q[c] <= rd_ptr_q[c] + PTR_ONE;
                end
                case ({push_s[c], pop_s[c]})
                    2'b10:   cnt_q[c] <= cnt_q[c] + FILL_ONE;
                    2'b01:   cnt_q[c] <= cnt_q[c] - FILL_ONE;
                    default: cnt_q[c] <= cnt_q[c];
                endcase
            end
        end
    end

`ifdef LOAD_CTRL_MC_ADDR_CHECK_EN
    logic [ADDR_WIDTH-1:0] exp_addr_q [NUM_CH];

    // A mismatch is only meaningful for a word that is actually delivered.
    always_comb begin
        oo_s = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            oo_s = oo_s | (pop_s[c] && (bus.request_addr != exp_addr_q[c]));
        end
    end

    // Resynchronise the expected address to the requester after every delivered word.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int c = 0; c < NUM_CH; c++) begin
                exp_addr_q[c] <= BASE_ADDR;
            end
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (pop_s[c]) begin
                    exp_addr_q[c] <= bus.request_addr + ADDR_WIDTH'(ADDR_STRIDE);
                end
            end
        end
    end
`else
    logic unused_addr_s;
    assign unused_addr_s = ^bus.request_addr;
    assign oo_s          = 1'b0;
`endif

    // Registered read data and one-cycle event pulses, aligned one cycle after the request.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            data_out_q     <= {DATA_WIDTH{1'b0}};
            data_out_vld_q <= 1'b0;
            data_out_ch_q  <= {CH_BITS{1'b0}};
            empty_ev_q     <= 1'b0;
            oo_ev_q        <= 1'b0;
            bad_ev_q       <= 1'b0;
        end else begin
            data_out_vld_q <= |pop_s;
            if (|pop_s) begin
                data_out_q    <= pop_data_s;
                data_out_ch_q <= bus.request_ch;
            end
            empty_ev_q <= empty_rd_s;
            oo_ev_q    <= oo_s;
            bad_ev_q   <= bad_ch_s;
        end
    end

    assign bus.data_out                                 = data_out_q;
    assign bus.data_out_vld                             = data_out_vld_q;
    assign bus.data_out_ch                              = data_out_ch_q;
    assign bus.event_read_req_when_no_data_is_available = empty_ev_q;
    assign bus.event_addr_out_of_order                  = oo_ev_q;
    assign bus.event_bad_channel                        = bad_ev_q;
endmodule
